// File: rtl/pc_exec_ctrl.sv
// Execution controller: sequences PC/pipeline advance from debug run/step/stop/clear
// commands, drains the pipeline after a HALT and parks the core.
module pc_exec_ctrl #(
    parameter int unsigned NBITS   = 32,
    parameter int unsigned N_DRAIN = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_step_req,
    input  logic             i_clear,
    input  logic             i_halt_detected,
    input  logic             i_stall,
    output logic             o_step,
    output logic             o_pc_write,
    output logic             o_running,
    output logic             o_halted,
    output logic [2:0]       o_state,
    output logic [NBITS-1:0] o_cycle_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(N_DRAIN - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] drain_cnt;
    logic [3:0] drain_next;
    logic       clear_count;
    logic       step;
    logic       pc_write_en;
    logic       running;
    logic       halted;
    logic [NBITS-1:0] cycle_count;

    always_comb begin
        state_next  = state;
        drain_next  = drain_cnt;
        clear_count = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = RUN;
                end else if (i_step_req) begin
                    state_next = STEP;
                end else if (i_clear) begin
                    clear_count = 1'b1;
                end
            end
            RUN: begin
                if (i_halt_detected) begin
                    state_next = DRAIN;
                    drain_next = DRAIN_LOAD;
                end else if (i_stop) begin
                    state_next = IDLE;
                end
            end
            STEP: begin
                if (i_halt_detected) begin
                    state_next = DRAIN;
                    drain_next = DRAIN_LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_next = HALTED;
                end else begin
                    drain_next = drain_cnt - 4'd1;
                end
            end
            HALTED: begin
                if (i_clear) begin
                    state_next  = IDLE;
                    clear_count = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= IDLE;
            drain_cnt   <= '0;
            cycle_count <= '0;
            step        <= 1'b0;
            pc_write_en <= 1'b0;
            running     <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_next;
            drain_cnt   <= drain_next;
            step        <= (state_next == RUN) || (state_next == STEP) || (state_next == DRAIN);
            pc_write_en <= (state_next == RUN) || (state_next == STEP);
            running     <= (state_next == RUN);
            halted      <= (state_next == HALTED);
            if (clear_count) begin
                cycle_count <= '0;
            end else if (step) begin
                cycle_count <= cycle_count + NBITS'(1);
            end
        end
    end

    assign o_step        = step;
    assign o_pc_write    = pc_write_en & ~i_stall;
    assign o_running     = running;
    assign o_halted      = halted;
    assign o_state       = state;
    assign o_cycle_count = cycle_count;

endmodule

// File: tb/tb_pc_exec_ctrl.sv
// Scoreboard bench for pc_exec_ctrl: the driver queues hand-computed per-cycle
// expectations, the monitor pops and compares them on the falling edge.
module tb_pc_exec_ctrl;

    localparam logic [5:0] ST  = 6'b100000;
    localparam logic [5:0] SP  = 6'b010000;
    localparam logic [5:0] SR  = 6'b001000;
    localparam logic [5:0] CL  = 6'b000100;
    localparam logic [5:0] HL  = 6'b000010;
    localparam logic [5:0] STL = 6'b000001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, step_req = 1'b0, clear = 1'b0;
    logic        halt = 1'b0, stall = 1'b0;
    logic        step, pc_write, running, halted;
    logic [2:0]  state;
    logic [31:0] cycle_count;

    typedef struct {
        int          id;
        logic [2:0]  st;
        logic        pcw;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;
    int   seq     = 0;

    pc_exec_ctrl #(.NBITS(32), .N_DRAIN(4)) dut (
        .i_clk           (clk),
        .i_reset         (rst_n),
        .i_start         (start),
        .i_stop          (stop),
        .i_step_req      (step_req),
        .i_clear         (clear),
        .i_halt_detected (halt),
        .i_stall         (stall),
        .o_step          (step),
        .o_pc_write      (pc_write),
        .o_running       (running),
        .o_halted        (halted),
        .o_state         (state),
        .o_cycle_count   (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input int id, input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, id, act, req);
        end
    endtask

    // One cycle: drive commands just after the rising edge and queue the outputs expected
    // during this cycle (before the commands are sampled at the next edge).
    task automatic cy(input logic rst, input logic [5:0] cmd, input logic [2:0] e_st,
                      input logic e_pcw, input logic [31:0] e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst;
        {start, stop, step_req, clear, halt, stall} = cmd;
        e.id  = seq++;
        e.st  = e_st;
        e.pcw = e_pcw;
        e.cnt = e_cnt;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.id, "state",    32'(state),    32'(e.st));
                check(e.id, "step",     32'(step),     32'((e.st == 3'd1) || (e.st == 3'd2) || (e.st == 3'd3)));
                check(e.id, "pc_write", 32'(pc_write), 32'(e.pcw));
                check(e.id, "running",  32'(running),  32'(e.st == 3'd1));
                check(e.id, "halted",   32'(halted),   32'(e.st == 3'd4));
                check(e.id, "count",    cycle_count,   e.cnt);
            end
        end
    end

    initial begin : driver
        int budget;
        // Reset held, then released with no commands
        repeat (2) cy(0, '0, 0, 0, 0);
        repeat (5) cy(1, '0, 0, 0, 0);

        // Three isolated single steps; a request during STEP is dropped
        cy(1, SR, 0, 0, 0);
        cy(1, '0, 2, 1, 0);
        cy(1, '0, 0, 0, 1);
        cy(1, SR, 0, 0, 1);
        cy(1, '0, 2, 1, 1);
        cy(1, '0, 0, 0, 2);
        cy(1, SR, 0, 0, 2);
        cy(1, SR, 2, 1, 2);
        cy(1, '0, 0, 0, 3);

        // Clear in IDLE, run 10 cycles with a stall in cycles 4-5, then stop
        cy(1, CL, 0, 0, 3);
        cy(1, ST, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            cy(1, ((i == 4 || i == 5) ? STL : 6'b0) | ((i == 10) ? SP : 6'b0),
               1, !(i == 4 || i == 5), 32'(i - 1));
        end
        cy(1, '0, 0, 0, 10);

        // HALT with simultaneous stop: drain ignores commands, HALTED ignores all but clear
        cy(1, CL, 0, 0, 10);
        cy(1, ST, 0, 0, 0);
        cy(1, '0, 1, 1, 0);
        cy(1, HL | SP, 1, 1, 1);
        for (int i = 0; i < 4; i++) cy(1, ST | SR | CL | SP | STL, 3, 0, 32'(2 + i));
        cy(1, ST, 4, 0, 6);
        cy(1, SR, 4, 0, 6);
        cy(1, HL, 4, 0, 6);
        cy(1, CL, 4, 0, 6);
        cy(1, '0, 0, 0, 0);

        // HALT during a stalled STEP cycle
        cy(1, SR, 0, 0, 0);
        cy(1, HL | STL, 2, 0, 0);
        for (int i = 0; i < 4; i++) cy(1, '0, 3, 0, 32'(1 + i));
        cy(1, '0, 4, 0, 5);
        cy(1, CL, 4, 0, 5);
        cy(1, '0, 0, 0, 0);

        // Reset asserted between edges mid-DRAIN takes effect before the next edge
        cy(1, ST, 0, 0, 0);
        cy(1, HL, 1, 1, 0);
        cy(1, '0, 3, 0, 1);
        cy(1, '0, 3, 0, 2);
        cy(0, '0, 0, 0, 0);
        cy(0, '0, 0, 0, 0);
        cy(1, '0, 0, 0, 0);
        cy(1, ST, 0, 0, 0);
        cy(1, SP, 1, 1, 0);
        cy(1, '0, 0, 0, 1);

        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            vectors++;
            errors++;
            $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
